hilo_muldiv_ctrl: RTL

//   Sequencer for the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO

---
 rtl/hilo_muldiv_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative sequencer for the HI/LO register pair.
// Runs MULT/MULTU/DIV/DIVU/MADD/MSUB one bit per cycle and handles MTHI/MTLO.
// The final 64-bit value always goes out as a plain HI/LO write.
//
//  state | meaning
//  IDLE  | waiting for Start; MTHI/MTLO data and divide-by-zero settled here
//  MUL   | one shift-add step per cycle on operand magnitudes
//  DIV   | one restoring-division step per cycle on operand magnitudes
//  FIX   | apply result signs; divides land as {remainder, quotient}
//  ACCUM | add/subtract the signed product into the current HI/LO value
//  WRITE | single-cycle WriteEn with registered data
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [WIDTH-1:0] CurHi,
  input  logic [WIDTH-1:0] CurLo,
  input  logic             ReadReq,
  output logic             Busy,
  output logic             Stall,
  output logic [WIDTH-1:0] WriteHiData,
  output logic [WIDTH-1:0] WriteLoData,
  output logic             WriteEn,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMadd  = 3'd4;
  localparam logic [2:0] OpMsub  = 3'd5;
  localparam logic [2:0] OpMthi  = 3'd6;
  localparam logic [2:0] OpMtlo  = 3'd7;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, ACCUM, WRITE} state_t;

  state_t state, stateNext;

  logic [2:0]         opReg;
  logic [CW-1:0]      iterCnt;
  logic [WIDTH-1:0]   mag;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   accHi;    // product high half / partial remainder
  logic [WIDTH-1:0]   accLo;    // multiplier shifting out / quotient shifting in
  logic               negRes;   // product or quotient must be negated
  logic               negRem;   // remainder must be negated (dividend was negative)

  logic               opSigned;
  logic               divOp;
  logic               accOp;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH-1:0]   divDiff;
  logic               divFits;
  logic [2*WIDTH-1:0] fixVal;
  logic [2*WIDTH-1:0] accumSum;

  assign opSigned = (Op == OpMult) || (Op == OpDiv) || (Op == OpMadd) || (Op == OpMsub);
  assign divOp    = (opReg == OpDiv) || (opReg == OpDivu);
  assign accOp    = (opReg == OpMadd) || (opReg == OpMsub);
  assign absA     = (opSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign absB     = (opSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  // The carry out of the high half is kept so unsigned max*max does not lose a bit.
  assign mulSum   = {1'b0, accHi} + {1'b0, mag};
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, mag};
  // When the divisor fits the difference is below mag, so WIDTH bits are enough.
  assign divDiff  = divShift[WIDTH-1:0] - mag;

  assign accumSum = (opReg == OpMsub) ? ({CurHi, CurLo} - {accHi, accLo})
                                      : ({CurHi, CurLo} + {accHi, accLo});

  // Sign correction: products negate as a whole, divides fix quotient and remainder separately.
  always_comb begin
    fixVal = negRes ? -{accHi, accLo} : {accHi, accLo};
    if (divOp) begin
      fixVal[WIDTH-1:0]       = negRes ? -accLo : accLo;
      fixVal[2*WIDTH-1:WIDTH] = negRem ? -accHi : accHi;
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode and status outputs.
  always_comb begin
    stateNext = state;
    Busy      = (state != IDLE);
    WriteEn   = (state == WRITE);
    case (state)
      IDLE: begin
        if (Start) begin
          case (Op)
            OpDiv, OpDivu:  stateNext = (OperandB == '0) ? IDLE : DIV;
            OpMthi, OpMtlo: stateNext = WRITE;
            default:        stateNext = MUL;
          endcase
        end
      end
      MUL, DIV: begin
        if (iterCnt == '0) stateNext = FIX;
      end
      FIX:     stateNext = accOp ? ACCUM : WRITE;
      ACCUM:   stateNext = WRITE;
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign Stall = Busy & (Start | ReadReq);

  // Operand latch, iteration datapath and write-data registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      opReg       <= '0;
      iterCnt     <= '0;
      mag         <= '0;
      accHi       <= '0;
      accLo       <= '0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      DivByZero   <= 1'b0;
      WriteHiData <= '0;
      WriteLoData <= '0;
    end else begin
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            opReg   <= Op;
            iterCnt <= LastIter;
            negRes  <= opSigned & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            negRem  <= opSigned & OperandA[WIDTH-1];
            accHi   <= '0;
            case (Op)
              OpDiv, OpDivu: begin
                accLo     <= absA;
                mag       <= absB;
                DivByZero <= (OperandB == '0);
              end
              OpMthi: begin
                WriteHiData <= OperandA;
                WriteLoData <= CurLo;
              end
              OpMtlo: begin
                WriteHiData <= CurHi;
                WriteLoData <= OperandA;
              end
              default: begin
                accLo <= absB;
                mag   <= absA;
              end
            endcase
          end
        end
        MUL: begin
          iterCnt <= iterCnt - CW'(1);
          if (accLo[0]) {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
          else          {accHi, accLo} <= {1'b0, accHi, accLo[WIDTH-1:1]};
        end
        DIV: begin
          iterCnt <= iterCnt - CW'(1);
          accHi   <= divFits ? divDiff : divShift[WIDTH-1:0];
          accLo   <= {accLo[WIDTH-2:0], divFits};
        end
        FIX: begin
          if (accOp) {accHi, accLo} <= fixVal;
          else       {WriteHiData, WriteLoData} <= fixVal;
        end
        ACCUM: begin
          {WriteHiData, WriteLoData} <= accumSum;
        end
        default: ;
      endcase
    end
  end

endmodule
